prince_quad_ti_stage: RTL and testbench

Registered, first-order threshold-implementation (TI) nonlinear stage for the 4-share masked PRINCE S-box datapath. It sits directly downstream of the linear A-layer and consumes its 4-share nibble outputs. Each share-split nibble goes through the shared quadratic map Q twice, G = Q∘Q, with a glitch-stopping register after each Q. The result is handed to the next linear layer. Masking is non-complete: output share i of each Q never depends on input share i.

---
 rtl/prince_quad_ti_stage.sv | 80 ++++++++
 tb/tb_prince_quad_ti_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prince_quad_ti_stage.sv
// Two-stage first-order threshold implementation of G = Q o Q for the 4-share PRINCE S-box.
// Each Q is followed by a register that stops glitches from reaching the next Q.
module prince_quad_ti_stage #(
    parameter int unsigned NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [16*NIBBLES-1:0]  in_shares,
    output logic                   out_valid,
    output logic [16*NIBBLES-1:0]  out_shares
);

    localparam int unsigned ShareW = 4 * NIBBLES;

    // One nibble: a[s*4 +: 4] is input share s. Output share i never sees input share i.
    function automatic logic [15:0] shared_q(input logic [15:0] a);
        logic [15:0] o;
        int          d;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            o[((j + 1) % 4) * 4 +: 4] ^= a[j * 4 +: 4];
            for (int k = 0; k < 4; k++) begin
                // Lowest share index that is neither j nor k
                d = (j != 0 && k != 0) ? 0 : ((j != 1 && k != 1) ? 1 : 2);
                o[d * 4 + 0] ^= a[j * 4 + 1] & a[k * 4 + 2];
                o[d * 4 + 1] ^= a[j * 4 + 2] & a[k * 4 + 3];
            end
        end
        return o;
    endfunction

    function automatic logic [16*NIBBLES-1:0] stage_q(input logic [16*NIBBLES-1:0] s);
        logic [16*NIBBLES-1:0] r;
        logic [15:0]           a;
        logic [15:0]           q;
        r = '0;
        for (int n = 0; n < int'(NIBBLES); n++) begin
            for (int sh = 0; sh < 4; sh++) begin
                a[sh * 4 +: 4] = s[sh * ShareW + 4 * n +: 4];
            end
            q = shared_q(a);
            for (int sh = 0; sh < 4; sh++) begin
                r[sh * ShareW + 4 * n +: 4] = q[sh * 4 +: 4];
            end
        end
        return r;
    endfunction

    logic [16*NIBBLES-1:0] q1_d;
    logic [16*NIBBLES-1:0] q2_d;
    logic [16*NIBBLES-1:0] r1_q;
    logic [16*NIBBLES-1:0] r2_q;
    logic                  v1_q;
    logic                  v2_q;

    always_comb begin
        q1_d = stage_q(in_shares);
        q2_d = stage_q(r1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q <= '0;
            r2_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (en) begin
            r1_q <= q1_d;
            r2_q <= q2_d;
            v1_q <= in_valid;
            v2_q <= v1_q;
        end
    end

    assign out_shares = r2_q;
    assign out_valid  = v2_q;

endmodule

// File: tb/tb_prince_quad_ti_stage.sv
// Scoreboard bench for prince_quad_ti_stage: expected unmasked G(x) values are queued on input
// and popped by a monitor that also checks the enabled-edge latency.
module tb_prince_quad_ti_stage;

    localparam int unsigned N = 16;
    localparam int unsigned W = 4 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           in_valid;
    logic [4*W-1:0] in_shares;
    logic           out_valid;
    logic [4*W-1:0] out_shares;

    prince_quad_ti_stage #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_shares  (in_shares),
        .out_valid  (out_valid),
        .out_shares (out_shares)
    );

    always #5 clk = ~clk;

    // Hand-derived G = Q o Q per nibble value
    logic [3:0] g_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hC, 4'hF, 4'hE};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] exp_q [$];
    int unsigned tag_q [$];
    int unsigned ecnt = 0;
    int unsigned seen = 0;

    function automatic logic [W-1:0] g_state(input logic [W-1:0] x);
        logic [W-1:0] g;
        for (int n = 0; n < int'(N); n++) g[4 * n +: 4] = g_tab[x[4 * n +: 4]];
        return g;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [4*W-1:0] s);
        return s[0 +: W] ^ s[W +: W] ^ s[2 * W +: W] ^ s[3 * W +: W];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_raw(input logic [4*W-1:0] s, input logic v);
        in_shares = s;
        in_valid  = v;
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] x, input logic v, input logic masked);
        logic [W-1:0] s1, s2, s3;
        s1 = masked ? {$urandom, $urandom} : '0;
        s2 = masked ? {$urandom, $urandom} : '0;
        s3 = masked ? {$urandom, $urandom} : '0;
        drive_raw({s3, s2, s1, x ^ s1 ^ s2 ^ s3}, v);
    endtask

    // Sampler: one entry per accepted valid, due one enabled edge after the capturing edge
    initial forever begin
        @(posedge clk);
        if (!rst && en) begin
            ecnt++;
            if (in_valid) begin
                exp_q.push_back(g_state(unmask(in_shares)));
                tag_q.push_back(ecnt + 1);
            end
        end
    end

    // Monitor: evaluate once per enabled edge
    initial forever begin
        @(negedge clk);
        if (!rst && ecnt != seen) begin
            seen = ecnt;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("latency", 64'(ecnt), 64'(tag_q[0]));
                    check("g_value", unmask(out_shares), exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                end
            end else if (tag_q.size() > 0 && tag_q[0] <= ecnt) begin
                check("missed_valid", 64'(out_valid), 64'd1);
                void'(exp_q.pop_front());
                void'(tag_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*W-1:0] s, base_r1;
        logic [W-1:0]   hold_share, delta;
        logic [4*W-1:0] hold_s;
        logic           hold_v;

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_shares = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_shares", unmask(out_shares) | out_shares[W +: W], 64'd0);
        rst = 1'b0;

        // Known answers, unmasked and masked
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drive(64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b0);
        drive(64'h6666_6666_6666_6666, 1'b1, 1'b0);
        drive(64'h0000_0000_0000_0000, 1'b1, 1'b0);
        drive(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        drive(64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
        repeat (3) drive('0, 1'b0, 1'b1);
        check("kat_drain", 64'(exp_q.size()), 64'd0);

        // Explicit constant known answer on the output port
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b1);
        check("kat_F_to_E", unmask(out_shares), 64'hEEEE_EEEE_EEEE_EEEE);
        drive(64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b1);
        check("kat_C_to_D", unmask(out_shares), 64'hDDDD_DDDD_DDDD_DDDD);

        // Bubbles 1,0,1,1,0
        drive(64'h1111_2222_3333_4444, 1'b1, 1'b1);
        drive(64'h5555_6666_7777_8888, 1'b0, 1'b1);
        drive(64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b1);
        drive(64'hDDDD_EEEE_FFFF_0000, 1'b1, 1'b1);
        drive(64'hC6C6_C6C6_C6C6_C6C6, 1'b0, 1'b1);
        repeat (3) drive('0, 1'b0, 1'b1);

        // Stall: 5 valids with en low for 3 cycles after the second
        drive(64'hCDEF_0123_4567_89AB, 1'b1, 1'b1);
        drive(64'hEEEE_CCCC_6666_FFFF, 1'b1, 1'b1);
        hold_s = out_shares;
        hold_v = out_valid;
        en = 1'b0;
        in_valid = 1'b1;
        in_shares = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            check("stall_shares", out_shares[0 +: W] ^ hold_s[0 +: W], 64'd0);
            check("stall_share3", out_shares[3 * W +: W], hold_s[3 * W +: W]);
            check("stall_valid", 64'(out_valid), 64'(hold_v));
        end
        en = 1'b1;
        drive(64'h0F0F_0F0F_C3C3_C3C3, 1'b1, 1'b1);
        drive(64'hDCBA_9876_5432_10FE, 1'b1, 1'b1);
        drive(64'h7E7E_6D6D_5C5C_4B4B, 1'b1, 1'b1);
        repeat (3) drive('0, 1'b0, 1'b1);
        check("stall_drain", 64'(exp_q.size()), 64'd0);

        // Non-completeness of stage 1: perturbing input share i leaves r1 share i unchanged
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 3; t++) begin
                s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                in_shares = s;
                in_valid = 1'b1;
                @(posedge clk); #1;
                base_r1 = dut.r1_q;
                hold_share = base_r1[i * W +: W];
                delta = {$urandom, $urandom} | 64'h1;
                s[i * W +: W] = s[i * W +: W] ^ delta;
                @(negedge clk);
                in_shares = s;
                @(posedge clk); #1;
                base_r1 = dut.r1_q;
                check("noncomplete", base_r1[i * W +: W], hold_share);
                @(negedge clk);
            end
        end
        repeat (3) drive('0, 1'b0, 1'b1);

        // Reset mid-stream: async clear without a clock edge
        drive(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
        drive(64'hFFFF_0000_CCCC_6666, 1'b1, 1'b1);
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_shares", out_shares[0 +: W] | out_shares[W +: W]
                                 | out_shares[2 * W +: W] | out_shares[3 * W +: W], 64'd0);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(64'hABCD_EF01_2345_6789, 1'b1, 1'b1);
        repeat (3) drive('0, 1'b0, 1'b1);
        check("post_reset_drain", 64'(exp_q.size()), 64'd0);

        // Random masked states, back to back
        for (int r = 0; r < 10000; r++) drive({$urandom, $urandom}, 1'b1, 1'b1);
        repeat (4) drive('0, 1'b0, 1'b1);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
